// File: rtl/thr_disc_pkg.sv
// Shared types and constants for the multi-channel ADC threshold discriminator.
package thr_disc_pkg;

    typedef enum logic [1:0] {
        MODE_ABOVE_LO = 2'd0,
        MODE_BELOW_HI = 2'd1,
        MODE_INSIDE   = 2'd2,
        MODE_OUTSIDE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ACTIVE    = 2'd2,
        RELEASING = 2'd3
    } state_e;

    // Two guard bits keep threshold +/- hysteresis from wrapping.
    localparam int unsigned EXT_MARGIN = 2;

    function automatic int unsigned ext_width(input int unsigned adc_w);
        return adc_w + EXT_MARGIN;
    endfunction

endpackage

// File: rtl/thr_disc_channel.sv
// One discriminator channel: registered compare stage, qualifier FSM with
// hysteresis/min-duration, and a saturating rising-edge event counter.
module thr_disc_channel
    import thr_disc_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = 14,
    parameter int unsigned HOLD_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        adc_clk,
    input  logic                        rst,
    input  logic signed [ADC_WIDTH-1:0] sample,
    input  mode_e                       mode,
    input  logic                        force_idle,
    input  logic signed [ADC_WIDTH-1:0] lo_thr,
    input  logic signed [ADC_WIDTH-1:0] hi_thr,
    input  logic [ADC_WIDTH-2:0]        hyst,
    input  logic [HOLD_WIDTH-1:0]       min_len,
    input  logic                        cnt_clr,
    output logic                        gate,
    output logic                        rise,
    output logic                        fall,
    output logic [CNT_WIDTH-1:0]        evt_cnt
);

    localparam int unsigned EXT_W = ext_width(ADC_WIDTH);
    localparam int unsigned HW1   = HOLD_WIDTH + 1;

    logic signed [EXT_W-1:0] d_x, lo_x, hi_x, hy_x, lo_m, lo_p, hi_m, hi_p;
    logic                    assert_c, release_c;
    logic                    a_q, r_q;

    state_e                  state_q, state_d;
    logic [HOLD_WIDTH-1:0]   cnt_q, cnt_d;
    logic [HW1-1:0]          n_len, cnt_inc;
    logic                    at_len, first_done;
    logic                    gate_d, rise_d, fall_d;

    // Compare stage at extended width
    always_comb begin
        d_x  = {{EXT_MARGIN{sample[ADC_WIDTH-1]}}, sample};
        lo_x = {{EXT_MARGIN{lo_thr[ADC_WIDTH-1]}}, lo_thr};
        hi_x = {{EXT_MARGIN{hi_thr[ADC_WIDTH-1]}}, hi_thr};
        hy_x = {{(EXT_MARGIN + 1){1'b0}}, hyst};
        lo_m = lo_x - hy_x;
        lo_p = lo_x + hy_x;
        hi_m = hi_x - hy_x;
        hi_p = hi_x + hy_x;
        assert_c  = 1'b0;
        release_c = 1'b0;
        case (mode)
            MODE_ABOVE_LO: begin
                assert_c  = (d_x >= lo_x);
                release_c = (d_x < lo_m);
            end
            MODE_BELOW_HI: begin
                assert_c  = (d_x <= hi_x);
                release_c = (d_x > hi_p);
            end
            MODE_INSIDE: begin
                assert_c  = (d_x >= lo_x) && (d_x <= hi_x);
                release_c = (d_x < lo_m) || (d_x > hi_p);
            end
            default: begin
                assert_c  = (d_x < lo_x) || (d_x > hi_x);
                release_c = (d_x >= lo_p) && (d_x <= hi_m);
            end
        endcase
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            a_q <= 1'b0;
            r_q <= 1'b0;
        end else begin
            a_q <= assert_c;
            r_q <= release_c;
        end
    end

    // Qualifier FSM; count is kept at zero in IDLE and ACTIVE
    always_comb begin
        n_len      = (min_len == '0) ? HW1'(1) : {1'b0, min_len};
        cnt_inc    = {1'b0, cnt_q} + HW1'(1);
        at_len     = (cnt_inc >= n_len);
        first_done = (n_len == HW1'(1));
        state_d    = state_q;
        cnt_d      = cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (force_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_q) begin
                        if (first_done) begin
                            state_d = ACTIVE;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ARMING;
                            cnt_d   = HOLD_WIDTH'(1);
                        end
                    end
                end
                ARMING: begin
                    if (!a_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (at_len) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[HOLD_WIDTH-1:0];
                    end
                end
                ACTIVE: begin
                    if (r_q) begin
                        if (first_done) begin
                            state_d = IDLE;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = RELEASING;
                            cnt_d   = HOLD_WIDTH'(1);
                        end
                    end
                end
                RELEASING: begin
                    if (!r_q) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else if (at_len) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[HOLD_WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        gate_d = (state_d == ACTIVE) || (state_d == RELEASING);
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gate    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate    <= gate_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Counts visible rise pulses; clear wins over increment
    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
        end else if (rise && (evt_cnt != '1)) begin
            evt_cnt <= evt_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/threshold_discriminator.sv
// Multi-channel ADC threshold discriminator: per-channel gate, edge pulses and
// event counters; a mode change or disable forces every channel idle.
module threshold_discriminator
    import thr_disc_pkg::*;
#(
    parameter int unsigned ADC_WIDTH        = 14,
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned N_CH             = 2,
    parameter int unsigned HOLD_WIDTH       = 8,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                               adc_clk,
    input  logic                               rst,
    input  logic [N_CH*AXIS_TDATA_WIDTH-1:0]   adc_dat,
    input  logic                               enable,
    input  mode_e                              mode,
    input  logic signed [ADC_WIDTH-1:0]        lo_thr,
    input  logic signed [ADC_WIDTH-1:0]        hi_thr,
    input  logic [ADC_WIDTH-2:0]               hyst,
    input  logic [HOLD_WIDTH-1:0]              min_len,
    input  logic                               cnt_clr,
    output logic [N_CH-1:0]                    gate,
    output logic [N_CH-1:0]                    rise,
    output logic [N_CH-1:0]                    fall,
    output logic [N_CH*CNT_WIDTH-1:0]          evt_cnt
);

    mode_e mode_q;
    logic  force_idle_c;

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_ABOVE_LO;
        end else begin
            mode_q <= mode;
        end
    end

    assign force_idle_c = (mode != mode_q) || !enable;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        if (AXIS_TDATA_WIDTH > ADC_WIDTH) begin : g_pad
            // Word bits above the sample are ignored
            logic unused_msbs;
            assign unused_msbs = ^adc_dat[ch*AXIS_TDATA_WIDTH+ADC_WIDTH +: AXIS_TDATA_WIDTH-ADC_WIDTH];
        end

        thr_disc_channel #(
            .ADC_WIDTH  (ADC_WIDTH),
            .HOLD_WIDTH (HOLD_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_channel (
            .adc_clk    (adc_clk),
            .rst        (rst),
            .sample     (adc_dat[ch*AXIS_TDATA_WIDTH +: ADC_WIDTH]),
            .mode       (mode),
            .force_idle (force_idle_c),
            .lo_thr     (lo_thr),
            .hi_thr     (hi_thr),
            .hyst       (hyst),
            .min_len    (min_len),
            .cnt_clr    (cnt_clr),
            .gate       (gate[ch]),
            .rise       (rise[ch]),
            .fall       (fall[ch]),
            .evt_cnt    (evt_cnt[ch*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule
